// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - round-robin arbiter with registered one-hot grant and bounded hold time
module rr_arbiter_8 #(
    parameter int NUM_REQ = 8,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W = $clog2(NUM_REQ),
    localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_gnt_vld,
    output logic               o_timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    logic               holder_req;
    logic               expired;
    logic               revoke;
    logic               arbitrate;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   pos;

    assign holder_req = i_req[o_gnt_idx];
    assign expired    = (cnt == CNT_W'(MAX_HOLD));
    assign revoke     = (state == GRANT) && i_en && holder_req && expired;
    assign arbitrate  = i_en && ((state == IDLE) || !holder_req || expired);

    // A holder that timed out is excluded from the re-arbitration it triggered.
    always_comb begin
        eligible = i_req;
        if (revoke) begin
            eligible[o_gnt_idx] = 1'b0;
        end
    end

    // Rotating priority search starting at ptr; index arithmetic wraps since NUM_REQ is a power of 2.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = ptr + IDX_W'(i);
            if (!found && eligible[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            o_gnt     <= '0;
            o_gnt_idx <= '0;
            o_gnt_vld <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= revoke;
            if (!i_en) begin
                state     <= IDLE;
                o_gnt     <= '0;
                o_gnt_vld <= 1'b0;
            end else if (arbitrate) begin
                if (found) begin
                    state     <= GRANT;
                    o_gnt     <= NUM_REQ'(1) << win;
                    o_gnt_idx <= win;
                    o_gnt_vld <= 1'b1;
                    cnt       <= CNT_W'(1);
                    ptr       <= win + IDX_W'(1);
                end else begin
                    state     <= IDLE;
                    o_gnt     <= '0;
                    o_gnt_vld <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8 (directed table, corner sequences, random vs model)
module tb_rr_arbiter_8;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference state, kept as plain integers.
    int m_vld = 0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_to  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter_8 #(.NUM_REQ(8), .MAX_HOLD(MH)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_req     (req),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx),
        .o_gnt_vld (gnt_vld),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic award(input logic [7:0] v);
        int w;
        w = -1;
        for (int j = 0; j < 8; j++) begin
            if (w < 0 && v[(m_ptr + j) % 8]) w = (m_ptr + j) % 8;
        end
        if (w >= 0) begin
            m_vld = 1;
            m_idx = w;
            m_cnt = 1;
            m_ptr = (w + 1) % 8;
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        logic [7:0] masked;
        if (r) begin
            m_vld = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!e) begin
                m_vld = 0;
            end else if (!m_vld) begin
                award(q);
            end else if (!q[m_idx]) begin
                award(q);
            end else if (m_cnt == MH) begin
                m_to = 1;
                masked = q;
                masked[m_idx] = 1'b0;
                award(masked);
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [7:0] q);
        rst = r; en = e; req = q;
        @(posedge clk);
        #1;
        model_step(r, e, q);
    endtask

    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                         input logic ev, input logic et);
        checks += 4;
        if (gnt !== eg) begin
            errors++;
            $display("FAIL %s: o_gnt got %h want %h", name, gnt, eg);
        end
        if (gnt_idx !== ei) begin
            errors++;
            $display("FAIL %s: o_gnt_idx got %0d want %0d", name, gnt_idx, ei);
        end
        if (gnt_vld !== ev) begin
            errors++;
            $display("FAIL %s: o_gnt_vld got %b want %b", name, gnt_vld, ev);
        end
        if (timeout !== et) begin
            errors++;
            $display("FAIL %s: o_timeout got %b want %b", name, timeout, et);
        end
    endtask

    task automatic check_model(input string name);
        logic [7:0] eg;
        eg = (m_vld != 0) ? (8'd1 << m_idx) : 8'd0;
        check(name, eg, 3'(m_idx), m_vld != 0, m_to != 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00;

        // reset, timeout rotation, lone-requester timeout
        tbl.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'h05, 8'h00, 3'd0, 1'b0, 1'b0});
        for (int n = 0; n < 4; n++) tbl.push_back('{1'b0, 1'b1, 8'h05, 8'h01, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h05, 8'h04, 3'd2, 1'b1, 1'b1});
        for (int n = 0; n < 3; n++) tbl.push_back('{1'b0, 1'b1, 8'h05, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h05, 8'h01, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0});
        for (int n = 0; n < 4; n++) tbl.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h08, 8'h00, 3'd3, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, tbl[i].en, tbl[i].req);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
        end

        // release handover
        cycle(1'b1, 1'b1, 8'h42); check("ho_rst",     8'h00, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h42); check("ho_first",   8'h02, 3'd1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 8'h40); check("ho_release", 8'h40, 3'd6, 1'b1, 1'b0);

        // holder keeps grant despite other bits; then wrap from ptr=7
        cycle(1'b0, 1'b1, 8'h41); check("wrap_hold",  8'h40, 3'd6, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h41); check("wrap_dis",   8'h00, 3'd6, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h41); check("wrap_win0",  8'h01, 3'd0, 1'b1, 1'b0);

        // enable drop and reset in the middle of a grant
        cycle(1'b1, 1'b1, 8'h20); check("en_rst",     8'h00, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h20); check("en_g5",      8'h20, 3'd5, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'hFF); check("en_low",     8'h00, 3'd5, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hFF); check("en_win6",    8'h40, 3'd6, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'h20); check("mr_rst",     8'h00, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h20); check("mr_g5",      8'h20, 3'd5, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'hFF); check("mr_midrst",  8'h00, 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hFF); check("mr_win0",    8'h01, 3'd0, 1'b1, 1'b0);

        // random traffic against the reference model
        cycle(1'b1, 1'b1, 8'h00); check_model("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            logic       r;
            logic       e;
            logic [7:0] q;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 15) != 0);
            case ($urandom_range(0, 3))
                0:       q = 8'($urandom) & 8'($urandom) & 8'($urandom);
                1:       q = 8'(1) << $urandom_range(0, 7);
                2:       q = req;
                default: q = 8'($urandom);
            endcase
            cycle(r, e, q);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Round-robin arbiter that shares one downstream resource among 8 requesters. It produces a registered one-hot grant and its matching binary index, and enforces a bounded hold time per grant. It sits in front of the shared datapath; the one-hot grant drives the resource-select lines directly.

Parameters:
NUM_REQ, 8, number of requesters; must be a power of 2 and at least 2. IDX_W = clog2(NUM_REQ) is a derived localparam.
MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; must be at least 1. The counter width is clog2(MAX_HOLD+1).

Ports:
i_clk  input  1  single clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_en  input  1  arbiter enable; when low, no grant is issued or held.
i_req  input  NUM_REQ  level request, one bit per requester.
o_gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
o_gnt_idx  output  IDX_W  binary index of the current holder; holds its last value when o_gnt_vld=0.
o_gnt_vld  output  1  high while any grant is active.
o_timeout  output  1  one-cycle pulse when a grant is revoked because MAX_HOLD expired.

Behaviour:
- Interface fixed: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values: o_gnt=0, o_gnt_idx=0, o_gnt_vld=0, o_timeout=0. Internal state: ptr=0, cnt=0, state=IDLE. Reset has priority over every other input, including mid-grant.
- Search order: starting at ptr, check ptr, ptr+1, … modulo NUM_REQ. The first set bit of the eligible request vector wins.
- States: IDLE and GRANT.
- IDLE: at an edge where i_en=1 and |i_req:
  - winner W registered: o_gnt=1<<W, o_gnt_idx=W, o_gnt_vld=1, cnt=1, ptr=(W+1) mod NUM_REQ, state=GRANT.
  - Otherwise remain in IDLE with outputs cleared.
  - Latency: request sampled at edge k, grant visible immediately after edge k.
- GRANT, evaluated at each edge, conditions in priority order:
  1. i_en=0: o_gnt=0, o_gnt_vld=0, no timeout pulse, ptr unchanged, go to IDLE.
  2. i_req[idx]=0 (holder released): re-arbitrate in the same edge over i_req.
  3. i_req[idx]=1 and cnt==MAX_HOLD: o_timeout=1 for one cycle. Re-arbitrate in the same edge with the holder's bit masked out.
  4. Otherwise hold the grant; cnt increments.
- Re-arbitration result:
  - Winner found: new grant takes effect with zero bubble, cnt=1, ptr updated as in IDLE.
  - No winner: outputs cleared, state=IDLE.
- A lone requester that times out therefore sees exactly one idle cycle, then is re-granted.
- o_gnt_vld high implies o_gnt has exactly one bit set, equal to 1<<o_gnt_idx.
- o_timeout is 0 in every cycle not immediately following a timeout edge.
- Changes to non-holder request bits during GRANT have no effect until the next arbitration.
- Pointer wrap: after a grant to NUM_REQ-1, ptr=0.

Test Plan:
1. Reset: i_rst=1 for 2 cycles with i_req=8'hFF, i_en=1 -> all outputs 0 during reset; first edge after release gives o_gnt=8'h01, o_gnt_idx=0.
2. Timeout rotation (MAX_HOLD=4): i_req=8'h05 held, i_en=1 -> grant to 0 for 4 cycles; o_timeout pulse with o_gnt=8'h04 on the next cycle (zero bubble); grant to 2 for 4 cycles; then back to 0.
3. Lone requester timeout: i_req=8'h08 held -> idx 3 for 4 cycles, then timeout pulse with o_gnt_vld=0 for one cycle, then re-grant to idx 3.
4. Release handover: idx 1 granted, i_req changes from 8'h42 to 8'h40 -> next edge o_gnt=8'h40, o_gnt_idx=6, o_timeout=0.
5. Wrap-around: after a grant to 6 (ptr=7), release with i_req=8'h41 -> winner is 0, not 6.
6. Mid-grant disruptions:
   - i_en=0 during a grant to 5 -> outputs cleared next edge; after i_en=1 with i_req=8'hFF, winner is 6.
   - i_rst=1 during a grant to 5 -> outputs cleared; after reset with i_req=8'hFF, winner is 0.
